// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the execute stage: multi-cycle mult/div with a fixed
// latency counter, single-cycle mthi/mtlo, and the architectural HI/LO registers.
module mul_div_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q;
  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  logic        is_mul, is_div, div_by_zero;
  logic        a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of trapping.
  always_comb begin
    is_mul      = (op_q == OpMult) || (op_q == OpMultu);
    is_div      = (op_q == OpDiv) || (op_q == OpDivu);
    div_by_zero = is_div && (b_q == 32'd0);

    a_ext = (op_q == OpMult) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext = (op_q == OpMult) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod  = a_ext * b_ext;

    a_neg = (op_q == OpDiv) && a_q[31];
    b_neg = (op_q == OpDiv) && b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end

    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
      res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      op_q    <= OpNone;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              OpMult, OpMultu, OpDiv, OpDivu: begin
                op_q    <= op;
                a_q     <= a;
                b_q     <= b;
                cnt_q   <= ((op == OpMult) || (op == OpMultu)) ? 4'(MUL_CYCLES)
                                                               : 4'(DIV_CYCLES);
                state_q <= StRun;
                busy_q  <= 1'b1;
              end
              OpMthi:  hi_q <= a;
              OpMtlo:  lo_q <= a;
              default: ;
            endcase
          end
        end
        StRun: begin
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            if (!div_by_zero) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO pairs are queued when an operation is
// issued and popped when the unit reports completion.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       tag;
  } exp_t;
  exp_t sb[$];

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle op, scramble the operand buses, then time busy and check the result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] eh, input logic [31:0] el, input int n,
                        input string tag);
    exp_t e;
    int   cyc;
    e.hi = eh; e.lo = el; e.cycles = n; e.tag = tag;
    sb.push_back(e);
    start = 1'b1; op = o; a = va; b = vb;
    step();
    start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    e = sb.pop_front();
    check({e.tag, " busy cycles"}, 64'(cyc), 64'(e.cycles));
    check({e.tag, " hi"}, {32'd0, hi}, {32'd0, e.hi});
    check({e.tag, " lo"}, {32'd0, lo}, {32'd0, e.lo});
  endtask

  initial begin
    exp_t e;
    int   cyc;

    // Power-on reset, some activity, then reset again with start asserted.
    step(); step();
    reset = 1'b1;
    start = 1'b1; op = 3'd5; a = 32'hA5A5_0001; step();
    op = 3'd6; a = 32'h5A5A_0002; step();
    op = 3'd1; a = 32'd7; b = 32'd9; step();
    start = 1'b0; step();
    reset = 1'b0;
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    step(); step();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);
    start = 1'b0; op = 3'd0;
    reset = 1'b1;
    step();
    check("post-reset idle", {31'd0, busy, hi}, 64'd0);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult");
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, "multu");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10, "divu");
    run_op(3'd3, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 10, "div +/-");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, "div ovf");
    run_op(3'd4, 32'h1234_5678, 32'd0, 32'h0000_0000, 32'h8000_0000, 10, "divu by 0");

    // mthi: single-cycle, no busy, old value visible until the writing edge.
    e.hi = 32'h1234_5678; e.lo = 32'h8000_0000; e.cycles = 0; e.tag = "mthi";
    sb.push_back(e);
    start = 1'b1; op = 3'd5; a = 32'h1234_5678;
    #3;
    check("mthi pre-edge hi", {32'd0, hi}, 64'd0);
    step();
    start = 1'b0; op = 3'd0;
    e = sb.pop_front();
    check("mthi busy", {63'd0, busy}, 64'd0);
    check("mthi hi/lo", {hi, lo}, {e.hi, e.lo});

    run_op(3'd6, 32'hCAFE_F00D, 32'd0, 32'h1234_5678, 32'hCAFE_F00D, 0, "mtlo");

    // mtlo and mthi presented while a mult is running must be ignored.
    e.hi = 32'h0000_0000; e.lo = 32'h0000_0023; e.cycles = 5; e.tag = "mult w/ mtlo";
    sb.push_back(e);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd7;
    step();
    start = 1'b0; op = 3'd0; a = 32'd1; b = 32'd1;
    step();
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; step();
    op = 3'd5; a = 32'hBEEF_DEAD; step();
    op = 3'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; step();
    start = 1'b0; op = 3'd0;
    cyc = 4;
    while (busy === 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    e = sb.pop_front();
    check("mult w/ mtlo busy cycles", 64'(cyc), 64'(e.cycles));
    check("mult w/ mtlo hi/lo", {hi, lo}, {e.hi, e.lo});
    step(); step();
    check("ignored op no restart", {63'd0, busy}, 64'd0);

    // Reset mid-run: busy drops next edge and the aborted quotient never lands.
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0; op = 3'd0;
    step(); step();
    check("pre-abort busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 15; i++) step();
    check("abort no write", {31'd0, busy, hi, lo[31:0]} , 64'd0);
    check("abort hi/lo", {hi, lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
